// File: rtl/mult_accumulator.sv
// mult_accumulator: MAC back-end that sums split multiplier products into a
// guarded accumulator and emits one result per frame over valid/ready.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   in_valid/in_ready      product beat handshake (in_ready low only in HOLD)
//   product1, product2     low / high halves of the 2*DWIDTH product
//   in_last                accepted beat closes the frame
//   acc_clear              drop the partial sum (ignored while a result is pending)
//   out_valid/out_ready    frame result handshake
//   out_acc                accumulated sum, ACCW bits
//   out_count              beats in the frame, saturating
//   out_overflow           accumulator overflowed at some point in the frame
module mult_accumulator #(
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned GUARD    = 8,
    parameter int unsigned CNTW     = 8,
    parameter int unsigned SATURATE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DWIDTH-1:0]            product1,
    input  logic [DWIDTH-1:0]            product2,
    input  logic                         in_last,
    input  logic                         acc_clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*DWIDTH+GUARD-1:0]    out_acc,
    output logic [CNTW-1:0]              out_count,
    output logic                         out_overflow
);

    localparam int unsigned ACCW = 2 * DWIDTH + GUARD;
    localparam int unsigned SUMW = ACCW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state;
    logic [ACCW-1:0]   acc;
    logic [CNTW-1:0]   count;
    logic              overflow;

    logic              accept;
    logic [ACCW-1:0]   base_acc;
    logic [CNTW-1:0]   base_cnt;
    logic              base_ovf;
    logic [SUMW-1:0]   prod_ext;
    logic [SUMW-1:0]   sum;
    logic [ACCW-1:0]   nxt_acc;
    logic [CNTW-1:0]   nxt_cnt;
    logic              nxt_ovf;

    // Ready depends on state alone so upstream never sees a valid->ready path.
    assign in_ready = (state != HOLD);
    assign accept   = in_valid && in_ready;

    // Next accumulator values for an accepted beat; acc_clear makes the beat
    // the first of a fresh frame.
    always_comb begin
        base_acc = acc_clear ? '0 : acc;
        base_cnt = acc_clear ? '0 : count;
        base_ovf = acc_clear ? 1'b0 : overflow;
        prod_ext = SUMW'({product2, product1});
        sum      = SUMW'(base_acc) + prod_ext;
        nxt_ovf  = base_ovf | sum[ACCW];
        if (sum[ACCW] && (SATURATE != 0)) begin
            nxt_acc = '1;
        end else begin
            nxt_acc = sum[ACCW-1:0];
        end
        if (base_cnt == '1) begin
            nxt_cnt = base_cnt;
        end else begin
            nxt_cnt = base_cnt + CNTW'(1);
        end
    end

    // Frame state machine with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            out_valid    <= 1'b0;
            out_acc      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc      <= nxt_acc;
                        count    <= nxt_cnt;
                        overflow <= nxt_ovf;
                        if (in_last) begin
                            out_acc      <= nxt_acc;
                            out_count    <= nxt_cnt;
                            out_overflow <= nxt_ovf;
                            out_valid    <= 1'b1;
                            state        <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end else if (acc_clear) begin
                        acc      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        state    <= IDLE;
                    end
                end
                HOLD: begin
                    // out_valid is always high here; completion needs only out_ready.
                    if (out_ready) begin
                        acc       <= '0;
                        count     <= '0;
                        overflow  <= 1'b0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
